// File: rtl/cla_add_pipe.sv
// cla_add_pipe: pipelined carry-lookahead adder/subtractor built from 4-bit
// lookahead groups. Each stage resolves GPS groups and hands the running carry
// to the next stage; a single global advance signal stalls the whole pipe.
// Optional feature macro: CLA_ADD_PIPE_SAT_EN (signed saturation of sum).
module cla_add_pipe #(
   parameter int WIDTH = 16,
   parameter int GPS   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             zero
);

   localparam int NG = WIDTH / 4;
   localparam int L  = NG / GPS;

   if ((WIDTH < 4) || (WIDTH % 4 != 0) || (GPS < 1) || (NG % GPS != 0)) begin : g_bad_cfg
      $error("cla_add_pipe: WIDTH must be a multiple of 4 and WIDTH/4 divisible by GPS");
   end

   // One 4-bit full-lookahead group: returns {carry_out, sum[3:0]}.
   function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                       input logic ci);
      logic [3:0] g;
      logic [3:0] p;
      logic [3:0] c;
      logic       co;
      g    = x & y;
      p    = x | y;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      return {co, x ^ y ^ c};
   endfunction

   logic advance;

   // Per-stage inputs (from ports for stage 0, else from the previous register)
   logic             st_in_v   [L];
   logic             st_in_c   [L];
   logic [WIDTH-1:0] st_in_sum [L];
   logic [WIDTH-1:0] st_in_a   [L];
   logic [WIDTH-1:0] st_in_bp  [L];

   // Per-stage combinational results
   logic             st_nxt_c   [L];
   logic [WIDTH-1:0] st_nxt_sum [L];

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Subtraction enters as A + ~B + 1; the inverted operand and forced carry
   // are fixed at entry so they travel with the beat.
   assign st_in_v[0]   = in_valid;
   assign st_in_c[0]   = sub ? 1'b1 : c_in;
   assign st_in_sum[0] = '0;
   assign st_in_a[0]   = a;
   assign st_in_bp[0]  = sub ? ~b : b;

   for (genvar k = 0; k < L; k++) begin : g_stage
      logic [4:0] grp;
      logic       carry;

      // Resolve this stage's groups; carries ripple group to group.
      always_comb begin
         carry         = st_in_c[k];
         grp           = '0;
         st_nxt_sum[k] = st_in_sum[k];
         for (int unsigned j = 0; j < GPS; j++) begin
            grp = cla4(st_in_a[k][(k*GPS+j)*4 +: 4], st_in_bp[k][(k*GPS+j)*4 +: 4], carry);
            st_nxt_sum[k][(k*GPS+j)*4 +: 4] = grp[3:0];
            carry = grp[4];
         end
         st_nxt_c[k] = carry;
      end

      if (k < L - 1) begin : g_reg
         logic             v_q;
         logic             c_q;
         logic [WIDTH-1:0] sum_q;
         logic [WIDTH-1:0] a_q;
         logic [WIDTH-1:0] bp_q;

         // Stage register: shifts on advance, data only loaded for real beats.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_q   <= 1'b0;
               c_q   <= 1'b0;
               sum_q <= '0;
               a_q   <= '0;
               bp_q  <= '0;
            end else if (advance) begin
               v_q <= st_in_v[k];
               if (st_in_v[k]) begin
                  c_q   <= st_nxt_c[k];
                  sum_q <= st_nxt_sum[k];
                  a_q   <= st_in_a[k];
                  bp_q  <= st_in_bp[k];
               end
            end
         end

         assign st_in_v[k+1]   = v_q;
         assign st_in_c[k+1]   = c_q;
         assign st_in_sum[k+1] = sum_q;
         assign st_in_a[k+1]   = a_q;
         assign st_in_bp[k+1]  = bp_q;
      end else begin : g_out
         logic             a_msb;
         logic             bp_msb;
         logic             ovf_c;
         logic             zero_c;
         logic [WIDTH-1:0] res_c;

         // Final stage: overflow, optional clamp, and zero from the final sum.
         always_comb begin
            a_msb  = st_in_a[k][WIDTH-1];
            bp_msb = st_in_bp[k][WIDTH-1];
            ovf_c  = (a_msb == bp_msb) && (st_nxt_sum[k][WIDTH-1] != a_msb);
            res_c  = st_nxt_sum[k];
`ifdef CLA_ADD_PIPE_SAT_EN
            if (ovf_c) begin
               res_c = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
            zero_c = (res_c == '0);
         end

         // Output register: the last pipeline stage.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_valid <= 1'b0;
               sum       <= '0;
               c_out     <= 1'b0;
               ovf       <= 1'b0;
               zero      <= 1'b0;
            end else if (advance) begin
               out_valid <= st_in_v[k];
               if (st_in_v[k]) begin
                  sum   <= res_c;
                  c_out <= st_nxt_c[k];
                  ovf   <= ovf_c;
                  zero  <= zero_c;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_cla_add_pipe.sv
// Self-checking bench for cla_add_pipe (WIDTH=16, GPS=1, four stages).
// Expected results come from a signed/unsigned integer arithmetic model.
module tb_cla_add_pipe;

   localparam int W   = 16;
   localparam int GPS = 1;
   localparam int L   = W / (4 * GPS);

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovf;
   logic         zero;

   cla_add_pipe #(.WIDTH(W), .GPS(GPS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .ovf       (ovf),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
      logic         z;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   chk_lat  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic sb);
      exp_t   e;
      longint ux, uy, sx, sy, u, s;
      ux = longint'(x);
      uy = longint'(y);
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (sb) begin
         u    = ux - uy;
         s    = sx - sy;
         e.co = (ux >= uy);
      end else begin
         u    = ux + uy + longint'(ci);
         s    = sx + sy + longint'(ci);
         e.co = (u > (longint'(1) << W) - 1);
      end
      e.s  = u[W-1:0];
      e.ov = (s > (longint'(1) << (W-1)) - 1) || (s < -(longint'(1) << (W-1)));
`ifdef CLA_ADD_PIPE_SAT_EN
      if (e.ov) e.s = (s > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
      e.z   = (e.s == '0);
      e.acc = 0;
      return e;
   endfunction

   // One cycle: drive at negedge, then score retirement and acceptance
   // that the coming rising edge will perform.
   task automatic step(input bit iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input bit ic, input bit is, input bit ordy);
      exp_t e;
      @(negedge clk);
      in_valid  = iv;
      a         = ia;
      b         = ib;
      c_in      = ic;
      sub       = is;
      out_ready = ordy;
      #1;
      cyc++;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            check("spurious_out", out_valid, 0);
         end else begin
            e = q.pop_front();
            check("sum", sum, e.s);
            check("c_out", c_out, e.co);
            check("ovf", ovf, e.ov);
            check("zero", zero, e.z);
            if (chk_lat) check("latency", cyc - e.acc, L);
         end
      end
      if (in_valid && in_ready) begin
         e     = model(ia, ib, ic, is);
         e.acc = cyc;
         q.push_back(e);
      end
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, ordy);
   endtask

   logic [W-1:0] snap;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      c_in      = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      #3;
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_c_out", c_out, 0);
      check("rst_ovf", ovf, 0);
      check("rst_zero", zero, 0);
      check("rst_in_ready", in_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", in_ready, 1);

      // Directed back-to-back stream with latency check
      chk_lat = 1;
      step(1, 16'h00FF, 16'h0001, 0, 0, 1);
      step(1, 16'hFFFF, 16'h0000, 1, 0, 1);
      step(1, 16'h0005, 16'h0007, 0, 1, 1);
      step(1, 16'h8000, 16'h0001, 0, 1, 1);
      step(1, 16'h7FFF, 16'h0001, 0, 0, 1);
      step(1, 16'h0000, 16'h8000, 0, 1, 1);
      step(1, 16'h1234, 16'h1234, 1, 1, 1);
      idle(L + 2, 1);
      chk_lat = 0;
      check("drain_stream", q.size(), 0);

      // Backpressure: three beats in flight, five stalled cycles
      step(1, 16'h1111, 16'h2222, 0, 0, 0);
      step(1, 16'hF000, 16'h1000, 0, 0, 0);
      step(1, 16'h0003, 16'h0009, 0, 1, 0);
      idle(L, 0);
      snap = sum;
      for (int i = 0; i < 5; i++) begin
         step(1, 16'hAAAA, 16'h5555, 0, 0, 0);
         check("stall_in_ready", in_ready, 0);
         check("stall_out_valid", out_valid, 1);
         check("stall_sum", sum, snap);
      end
      idle(L + 2, 1);
      check("drain_stall", q.size(), 0);

      // Reset with two beats in flight
      step(1, 16'h0101, 16'h0202, 0, 0, 0);
      step(1, 16'h0303, 16'h0404, 0, 0, 0);
      idle(L, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_sum", sum, 0);
      q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 16'h0001, 16'h0001, 0, 0, 1);
      idle(L + 2, 1);
      check("drain_after_rst", q.size(), 0);

      // Randomized traffic with random backpressure
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) != 0);
      end
      idle(3 * L, 1);
      check("drain_random", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
